// File: rtl/reset_sequencer_pkg.sv
// Shared types and limits for the staged reset sequencer.
// The state enum is exported so other blocks can decode the sequencer state.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    RST       = 3'd0,
    WAIT_LINK = 3'd1,
    REL_CTRL  = 3'd2,
    RUN       = 3'd3,
    SW_HOLD   = 3'd4
  } seq_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int LINK_STABLE_MIN = 1;
  localparam int CTRL_DLY_MIN    = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single level signal; all stages reset to 0.
module bit_sync
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  localparam int N = max_int(STAGES, SYNC_STAGES_MIN);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: controller after a stable link, application CTRL_DLY
// cycles later, plus a four-phase software reset handshake.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LINK_STABLE = 8,
  parameter int CTRL_DLY    = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic link_up,
  input  logic sw_rst_req,
  output logic sw_rst_ack,
  output logic ctrl_rst_n,
  output logic app_rst_n,
  output logic reset_out,
  output logic seq_done
);

  localparam int LS = max_int(LINK_STABLE, LINK_STABLE_MIN);
  localparam int CD = max_int(CTRL_DLY, CTRL_DLY_MIN);
  localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LS - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(CD - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             link_s;
  logic             ctrl_rst_n_q, app_rst_n_q, reset_out_q, seq_done_q, sw_rst_ack_q;

  bit_sync #(.STAGES(SYNC_STAGES)) u_link_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (link_up),
    .q_o  (link_s)
  );

  // Saturating increment; terminal counts leave the state before the top is reached.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RST: begin
        state_d = WAIT_LINK;
        cnt_d   = '0;
      end
      WAIT_LINK: begin
        if (sw_rst_req) begin
          state_d = SW_HOLD;
          cnt_d   = '0;
        end else if (!link_s) begin
          cnt_d = '0;
        end else if (cnt_q == LS_LAST) begin
          state_d = REL_CTRL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REL_CTRL: begin
        if (sw_rst_req) begin
          state_d = SW_HOLD;
          cnt_d   = '0;
        end else if (!link_s) begin
          state_d = WAIT_LINK;
          cnt_d   = '0;
        end else if (cnt_q == CD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (sw_rst_req) begin
          state_d = SW_HOLD;
        end else if (!link_s) begin
          state_d = WAIT_LINK;
        end
      end
      SW_HOLD: begin
        cnt_d = '0;
        if (!sw_rst_req) begin
          state_d = WAIT_LINK;
        end
      end
      default: begin
        state_d = RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST;
      cnt_q        <= '0;
      ctrl_rst_n_q <= 1'b0;
      app_rst_n_q  <= 1'b0;
      reset_out_q  <= 1'b1;
      seq_done_q   <= 1'b0;
      sw_rst_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_rst_n_q <= (state_d == REL_CTRL) || (state_d == RUN);
      app_rst_n_q  <= (state_d == RUN);
      reset_out_q  <= (state_d != RUN);
      seq_done_q   <= (state_d == RUN);
      sw_rst_ack_q <= (state_d == SW_HOLD);
    end
  end

  assign ctrl_rst_n = ctrl_rst_n_q;
  assign app_rst_n  = app_rst_n_q;
  assign reset_out  = reset_out_q;
  assign seq_done   = seq_done_q;
  assign sw_rst_ack = sw_rst_ack_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumer-side counterpart to the die-level reset generator. Takes the raw asynchronous active-low reset plus the AIB link-up indication and releases staged synchronous resets: controller first, then application. The application is released only after the link has been stable for a programmable time. Also services a four-phase software reset request/acknowledge handshake. Sits between the reset input pin/link status and the AXI4-ST controller and application logic.

Parameters:
SYNC_STAGES, 2, flops in the link_up synchronizer (min 2)
LINK_STABLE, 8, consecutive synchronized link_up=1 samples required before controller release (min 1)
CTRL_DLY, 4, cycles between ctrl_rst_n and app_rst_n release (min 1)
CNT_W, 8, counter width; must hold max(LINK_STABLE, CTRL_DLY)

Ports:
clk  in  1  single block clock
rst_n  in  1  asynchronous active-low reset
link_up  in  1  AIB link status, asynchronous to clk, level
sw_rst_req  in  1  software reset request, synchronous level (four-phase)
sw_rst_ack  out  1  software reset acknowledge
ctrl_rst_n  out  1  controller reset, active-low, registered
app_rst_n  out  1  application reset, active-low, registered
reset_out  out  1  active-high copy of the application reset (~app_rst_n), registered
seq_done  out  1  high in RUN

Behaviour:
- One clock: clk. Reset rst_n is asynchronous assert and active-low. Every flop is reset by it.
- Reset values: ctrl_rst_n=0, app_rst_n=0, reset_out=1, seq_done=0, sw_rst_ack=0. State=RST, counter=0, synchronizer chain=0.
- All outputs are registered and decoded from the next state, so they change on the transition edge.
- link_up passes through a SYNC_STAGES flop chain; link_s is the final stage. No other logic touches raw link_up.
- States:
  - RST: all resets asserted. Next edge → WAIT_LINK unconditionally.
  - WAIT_LINK: all resets asserted. The counter increments on each edge with link_s=1 and clears on link_s=0. On the edge completing the LINK_STABLE-th consecutive 1 sample → REL_CTRL, ctrl_rst_n=1, counter cleared.
  - REL_CTRL: ctrl_rst_n=1, app_rst_n=0. Counter increments each edge. On the CTRL_DLY-th edge → RUN, app_rst_n=1, reset_out=0, seq_done=1.
  - RUN: all resets released, seq_done=1.
  - SW_HOLD: all resets asserted, sw_rst_ack=1. Leaves when sw_rst_req=0 → WAIT_LINK with sw_rst_ack=0 and counter cleared.
- Link drop: link_s=0 in REL_CTRL or RUN → WAIT_LINK. ctrl_rst_n and app_rst_n reassert on the same edge; seq_done=0; counter cleared.
- Software reset: sw_rst_req=1 in WAIT_LINK, REL_CTRL or RUN → SW_HOLD on the next edge.
  - The request is ignored in RST.
  - sw_rst_req has priority over a simultaneous link drop.
- Handshake: ack rises only after resets are asserted, on the same edge. The requester must hold req until it sees ack=1, then drop it. Ack drops one edge after req drops.
- Mid-sequence rst_n assertion forces the reset values immediately, with no clock required. Release restarts from RST.
- Glitch rule: a link_s=0 sample during WAIT_LINK restarts the full LINK_STABLE count.
- Counter saturates and never wraps, since terminal counts cause state exit.

Decomposition:
- Shared package: state enum (RST, WAIT_LINK, REL_CTRL, RUN, SW_HOLD) and the minimum-value constants for the parameters, so the bench can decode state.
- One sub-module: bit_sync, a parameterized SYNC_STAGES flop chain with async active-low reset to 0. It is reusable by other link-status inputs.
- The sequencer FSM and counter stay in the top module.

Test Plan:
- Power-up: rst_n low 5 cycles, link_up=1 throughout → outputs hold reset values during reset. With link_up=1 sampled from the first edge E0 after release: ctrl_rst_n=1 after E9, app_rst_n=1, reset_out=0, seq_done=1 after E13 (defaults).
- Link glitch: link_up=1 from E0, low for one cycle so link_s=0 at E5, then high → the count restarts. ctrl_rst_n release is delayed by the restart; app_rst_n stays 0 throughout.
- Link drop in RUN: deassert link_up → SYNC_STAGES edges later, ctrl_rst_n=0, app_rst_n=0, seq_done=0 on the same edge. Re-raise → full 8+4 sequence repeats.
- Software reset in RUN: sw_rst_req=1 → next edge resets asserted and sw_rst_ack=1. Hold req 10 cycles → ack stays 1. Drop req → ack=0 next edge, then the sequence re-releases after 8+4 edges with link_up=1.
- Simultaneous events: sw_rst_req rises on the same edge link_s falls in RUN → state goes to SW_HOLD, not WAIT_LINK; sw_rst_ack=1.
- Async reset mid-REL_CTRL: rst_n low between edges → ctrl_rst_n=0 immediately without a clock edge. After release → RST then WAIT_LINK, counter=0.
